// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache between the LC-3b memory
// port (16-bit words) and 128-bit line memory, with tree pseudo-LRU replacement.
module cache_nway_wb #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  mem_address,
  output logic [15:0]  mem_rdata,
  input  logic [15:0]  mem_wdata,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  input  logic [127:0] pmem_rdata,
  output logic [127:0] pmem_wdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG   = 12 - IDX;
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {ST_IDLE, ST_WBACK, ST_FILL, ST_HIT} state_t;
  state_t state, state_d;

  logic             req, is_write;
  logic [IDX-1:0]   idx;
  logic [TAG-1:0]   tag;
  logic [2:0]       word_sel;

  assign req      = mem_read | mem_write;
  assign is_write = mem_write;
  assign idx      = mem_address[4+IDX-1:4];
  assign tag      = mem_address[15:4+IDX];
  assign word_sel = mem_address[3:1];

  logic             unused_ok;
  assign unused_ok = &{1'b0, mem_address[0]};

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAYS-2:0]  plru_q  [SETS];
  logic [TAG-1:0]   tag_q   [SETS][WAYS];
  logic [127:0]     data_q  [SETS][WAYS];

  // Line address and victim way captured when a miss starts; the fill installs here.
  logic [11:0]      line_q;
  logic [WAY_W-1:0] victim_q;
  logic [IDX-1:0]   vidx;
  logic [TAG-1:0]   vtag;
  assign vidx = line_q[IDX-1:0];
  assign vtag = line_q[11:IDX];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic [WAYS-2:0]  plru_next;
  logic [127:0]     hit_line, merged_line;
  logic [15:0]      rd_word, wr_word;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest invalid way wins; otherwise follow the PLRU tree from the root.
  always_comb begin
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    int               node;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    node = 0;
    for (int l = 0; l < WAY_W; l++) node = 2 * node + 1 + int'(plru_q[idx][node]);
    victim = inv_found ? inv_way : WAY_W'(node - (WAYS - 1));
  end

  always_comb begin
    int   node;
    logic dir;
    plru_next = plru_q[idx];
    node      = 0;
    dir       = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      dir             = hit_way[WAY_W-1-l];
      plru_next[node] = ~dir;
      node            = 2 * node + 1 + int'(dir);
    end
  end

  always_comb begin
    hit_line = data_q[idx][hit_way];
    rd_word  = hit_line[16*int'(word_sel) +: 16];
    wr_word  = rd_word;
    if (mem_byte_enable[0]) wr_word[7:0]  = mem_wdata[7:0];
    if (mem_byte_enable[1]) wr_word[15:8] = mem_wdata[15:8];
    merged_line = hit_line;
    merged_line[16*int'(word_sel) +: 16] = wr_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (req) begin
        if (hit)                                          state_d = ST_HIT;
        else if (valid_q[idx][victim] && dirty_q[idx][victim]) state_d = ST_WBACK;
        else                                              state_d = ST_FILL;
      end
      ST_WBACK: if (pmem_resp) state_d = ST_FILL;
      ST_FILL:  if (pmem_resp) state_d = req ? ST_HIT : ST_IDLE;
      ST_HIT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state)
      ST_WBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[vidx][victim_q], vidx, 4'h0};
        pmem_wdata   = data_q[vidx][victim_q];
      end
      ST_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {line_q, 4'h0};
      end
      ST_HIT: begin
        mem_resp  = 1'b1;
        mem_rdata = rd_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      hit_count  <= '0;
      miss_count <= '0;
      line_q     <= '0;
      victim_q   <= '0;
    end else begin
      if (state == ST_IDLE && req) begin
        line_q   <= mem_address[15:4];
        victim_q <= victim;
        if (hit) hit_count  <= hit_count + 16'd1;
        else     miss_count <= miss_count + 16'd1;
      end
      if (state == ST_FILL && pmem_resp) begin
        valid_q[vidx][victim_q] <= 1'b1;
        dirty_q[vidx][victim_q] <= 1'b0;
      end
      if (state == ST_HIT && hit) begin
        plru_q[idx] <= plru_next;
        if (is_write) dirty_q[idx][hit_way] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data storage is not reset; valid bits alone decide whether contents count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_FILL && pmem_resp) begin
        data_q[vidx][victim_q] <= pmem_rdata;
        tag_q[vidx][victim_q]  <= vtag;
      end else if (state == ST_HIT && hit && is_write) begin
        data_q[idx][hit_way] <= merged_line;
      end
    end
  end
endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed bench for cache_nway_wb: CPU access tasks plus a 3-cycle line-memory model.
module tb_cache_nway_wb;
  logic         clk;
  logic         rst;
  logic [15:0]  mem_address, mem_rdata, mem_wdata;
  logic         mem_read, mem_write, mem_resp;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_rdata, pmem_wdata;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [15:0]  hit_count, miss_count;

  int tests_run, fails;

  cache_nway_wb #(.WAYS(4), .SETS(8)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line memory: word w of line L reads as {L, w}; line 0x123 word 2 holds 0x5566.
  logic [127:0] pmem_mem [4096];
  int           rd_cnt, wb_cnt, op_seq, rd_seq, wb_seq, pm_cnt;
  logic [15:0]  last_rd_addr, last_wb_addr;
  logic [127:0] last_wb_data;

  initial begin
    for (int l = 0; l < 4096; l++)
      for (int w = 0; w < 8; w++)
        pmem_mem[l][16*w +: 16] = {12'(l), 4'(w)};
    pmem_mem[12'h123][47:32] = 16'h5566;
    pmem_resp = 1'b0; pmem_rdata = '0;
    rd_cnt = 0; wb_cnt = 0; op_seq = 0; rd_seq = 0; wb_seq = 0; pm_cnt = 0;
    last_rd_addr = '0; last_wb_addr = '0; last_wb_data = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if ((pmem_read || pmem_write) && !rst) begin
        if (pm_cnt == 2) begin
          pm_cnt = 0;
          op_seq++;
          if (pmem_write) begin
            pmem_mem[pmem_address[15:4]] = pmem_wdata;
            last_wb_addr = pmem_address; last_wb_data = pmem_wdata;
            wb_cnt++; wb_seq = op_seq;
          end else begin
            pmem_rdata = pmem_mem[pmem_address[15:4]];
            last_rd_addr = pmem_address;
            rd_cnt++; rd_seq = op_seq;
          end
          pmem_resp = 1'b1;
        end else pm_cnt++;
      end else pm_cnt = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic access(input logic [15:0] a, input logic r, input logic w,
                        input logic [15:0] wd, input logic [1:0] be,
                        output logic [15:0] rdat, output int cyc);
    @(negedge clk);
    mem_address = a; mem_read = r; mem_write = w; mem_wdata = wd; mem_byte_enable = be;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!mem_resp && cyc < 200);
    if (!mem_resp) begin
      tests_run++; fails++;
      $display("FAIL access_timeout: addr %h got no mem_resp in %0d cycles", a, cyc);
    end
    rdat = mem_rdata;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    tests_run++;
    if (mem_resp !== 1'b0) begin fails++; $display("FAIL resp_pulse: addr %h mem_resp=%b want 0", a, mem_resp); end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (mem_resp !== 1'b0)   begin fails++; $display("FAIL reset_mem_resp: got %b want 0", mem_resp); end
    tests_run++; if (pmem_read !== 1'b0)  begin fails++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
    tests_run++; if (pmem_write !== 1'b0) begin fails++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
    tests_run++; if (hit_count !== 16'd0) begin fails++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
    tests_run++; if (miss_count !== 16'd0) begin fails++; $display("FAIL reset_miss_count: got %0d want 0", miss_count); end
    rst = 1'b0;
  endtask

  task automatic test_cold_read();
    logic [15:0] d; int c, rc0, wc0;
    rc0 = rd_cnt; wc0 = wb_cnt;
    access(16'h1234, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    tests_run++; if (d !== 16'h5566) begin fails++; $display("FAIL cold_rdata: got %h want 5566", d); end
    tests_run++; if (last_rd_addr !== 16'h1230) begin fails++; $display("FAIL cold_pmem_addr: got %h want 1230", last_rd_addr); end
    tests_run++; if (wb_cnt !== wc0) begin fails++; $display("FAIL cold_no_wb: got %0d writebacks want %0d", wb_cnt, wc0); end
    tests_run++; if (rd_cnt !== rc0 + 1) begin fails++; $display("FAIL cold_fill_count: got %0d want %0d", rd_cnt, rc0 + 1); end
    tests_run++; if (miss_count !== 16'd1) begin fails++; $display("FAIL cold_miss_count: got %0d want 1", miss_count); end
    tests_run++; if (hit_count !== 16'd0) begin fails++; $display("FAIL cold_hit_count: got %0d want 0", hit_count); end
    access(16'h1234, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    tests_run++; if (c !== 1) begin fails++; $display("FAIL hit_latency: got %0d cycles want 1", c); end
    tests_run++; if (d !== 16'h5566) begin fails++; $display("FAIL hit_rdata: got %h want 5566", d); end
    tests_run++; if (rd_cnt !== rc0 + 1) begin fails++; $display("FAIL hit_no_fill: got %0d fills want %0d", rd_cnt, rc0 + 1); end
    tests_run++; if (hit_count !== 16'd1) begin fails++; $display("FAIL hit_count: got %0d want 1", hit_count); end
  endtask

  task automatic test_write_hit();
    logic [15:0] d; int c;
    access(16'h1234, 1'b0, 1'b1, 16'hABCD, 2'b01, d, c);
    tests_run++; if (c !== 1) begin fails++; $display("FAIL wr_hit_latency: got %0d want 1", c); end
    access(16'h1234, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    tests_run++; if (d !== 16'h55CD) begin fails++; $display("FAIL wr_merge_rdata: got %h want 55cd", d); end
    tests_run++; if (miss_count !== 16'd1) begin fails++; $display("FAIL wr_miss_count: got %0d want 1", miss_count); end
    tests_run++; if (hit_count !== 16'd3) begin fails++; $display("FAIL wr_hit_count: got %0d want 3", hit_count); end
  endtask

  task automatic test_read_write_both();
    logic [15:0] d; int c, rc0;
    rc0 = rd_cnt;
    access(16'h1234, 1'b1, 1'b1, 16'h0F0F, 2'b11, d, c);
    tests_run++; if (c !== 1) begin fails++; $display("FAIL both_latency: got %0d want 1", c); end
    access(16'h1234, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    tests_run++; if (d !== 16'h0F0F) begin fails++; $display("FAIL both_as_write: got %h want 0f0f", d); end
    tests_run++; if (rd_cnt !== rc0) begin fails++; $display("FAIL both_no_fill: got %0d want %0d", rd_cnt, rc0); end
    tests_run++; if (hit_count !== 16'd5) begin fails++; $display("FAIL both_hit_count: got %0d want 5", hit_count); end
  endtask

  task automatic test_plru_clean();
    logic [15:0] d; int c, rc0, wc0;
    do_reset();
    access(16'h0030, 1'b0, 1'b1, 16'h1111, 2'b11, d, c);
    access(16'h0130, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    access(16'h0230, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    access(16'h0330, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    access(16'h0030, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    tests_run++; if (d !== 16'h1111 || c !== 1) begin fails++; $display("FAIL plru_rehit: got %h/%0d want 1111/1", d, c); end
    rc0 = rd_cnt; wc0 = wb_cnt;
    access(16'h0430, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    tests_run++; if (wb_cnt !== wc0) begin fails++; $display("FAIL plru_clean_no_wb: got %0d want %0d", wb_cnt, wc0); end
    tests_run++; if (last_rd_addr !== 16'h0430) begin fails++; $display("FAIL plru_fill_addr: got %h want 0430", last_rd_addr); end
    tests_run++; if (d !== 16'h0430) begin fails++; $display("FAIL plru_fill_rdata: got %h want 0430", d); end
    tests_run++; if (miss_count !== 16'd5 || hit_count !== 16'd1) begin fails++; $display("FAIL plru_counts: got %0d/%0d want 5/1", miss_count, hit_count); end
    access(16'h0130, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    tests_run++; if (c !== 1 || d !== 16'h0130) begin fails++; $display("FAIL plru_way1_kept: got %h/%0d want 0130/1", d, c); end
    rc0 = rd_cnt;
    access(16'h0230, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    tests_run++; if (rd_cnt !== rc0 + 1 || miss_count !== 16'd6) begin fails++; $display("FAIL plru_way2_evicted: got fills %0d miss %0d want %0d/6", rd_cnt, miss_count, rc0 + 1); end
  endtask

  task automatic test_plru_dirty();
    logic [15:0] d; int c, rc0, wc0;
    do_reset();
    access(16'h0030, 1'b0, 1'b1, 16'h1111, 2'b11, d, c);
    access(16'h0130, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    access(16'h0230, 1'b0, 1'b1, 16'h2222, 2'b11, d, c);
    access(16'h0330, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    access(16'h0030, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    rc0 = rd_cnt; wc0 = wb_cnt;
    access(16'h0430, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    tests_run++; if (wb_cnt !== wc0 + 1) begin fails++; $display("FAIL dirty_wb_count: got %0d want %0d", wb_cnt, wc0 + 1); end
    tests_run++; if (last_wb_addr !== 16'h0230) begin fails++; $display("FAIL dirty_wb_addr: got %h want 0230", last_wb_addr); end
    tests_run++; if (last_wb_data !== 128'h0237_0236_0235_0234_0233_0232_0231_2222) begin fails++; $display("FAIL dirty_wb_data: got %h", last_wb_data); end
    tests_run++; if (rd_cnt !== rc0 + 1 || last_rd_addr !== 16'h0430) begin fails++; $display("FAIL dirty_fill: got %0d fills addr %h want %0d/0430", rd_cnt, last_rd_addr, rc0 + 1); end
    tests_run++; if (wb_seq >= rd_seq) begin fails++; $display("FAIL dirty_order: wb seq %0d fill seq %0d want wb first", wb_seq, rd_seq); end
    tests_run++; if (d !== 16'h0430) begin fails++; $display("FAIL dirty_rdata: got %h want 0430", d); end
    access(16'h0230, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    tests_run++; if (d !== 16'h2222) begin fails++; $display("FAIL dirty_refetch: got %h want 2222", d); end
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] d; int c, rc0;
    @(negedge clk);
    mem_address = 16'h0530; mem_read = 1'b1; mem_write = 1'b0;
    for (c = 0; c < 50 && !pmem_read; c++) @(negedge clk);
    tests_run++; if (pmem_read !== 1'b1) begin fails++; $display("FAIL midfill_no_fill: pmem_read=%b want 1", pmem_read); end
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (pmem_read !== 1'b0) begin fails++; $display("FAIL midfill_pmem_read: got %b want 0", pmem_read); end
    tests_run++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin fails++; $display("FAIL midfill_counters: got %0d/%0d want 0/0", hit_count, miss_count); end
    @(negedge clk); rst = 1'b0;
    rc0 = rd_cnt;
    access(16'h0130, 1'b1, 1'b0, 16'h0, 2'b00, d, c);
    tests_run++; if (rd_cnt !== rc0 + 1 || miss_count !== 16'd1) begin fails++; $display("FAIL midfill_remiss: got fills %0d miss %0d want %0d/1", rd_cnt, miss_count, rc0 + 1); end
    tests_run++; if (d !== 16'h0130) begin fails++; $display("FAIL midfill_rdata: got %h want 0130", d); end
  endtask

  initial begin
    tests_run = 0; fails = 0;
    rst = 1'b1;
    mem_address = '0; mem_wdata = '0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_read_write_both();
    test_plru_clean();
    test_plru_dirty();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/cache_nway_wb.md
Name: cache_nway_wb

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache with tag/valid/dirty/data arrays and tree pseudo-LRU.
- Sits between the LC-3b CPU memory port (16-bit word, byte enables) and physical memory (128-bit line, 16-byte lines).
- Generalises the fixed 2-way/8-set controller to WAYS ways and SETS sets.
- Adds first-invalid-way fill, synchronous reset of all state, and wrapping hit/miss counters.

Parameters:
- WAYS, 4, associativity; power of 2, at least 2.
- SETS, 8, number of sets; power of 2, at least 2. IDX=log2(SETS), TAG=12-IDX.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_address  in  16  CPU byte address
- mem_rdata  out  16  read data
- mem_wdata  in  16  write data
- mem_read  in  1  read request
- mem_write  in  1  write request
- mem_byte_enable  in  2  byte mask; bit0 = low byte
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  16  line address, low 4 bits always 0
- pmem_rdata  in  128  fill line
- pmem_wdata  out  128  writeback line
- pmem_read  out  1  fill request
- pmem_write  out  1  writeback request
- pmem_resp  in  1  pmem completion
- hit_count  out  16  completed hits
- miss_count  out  16  misses

Interface decision: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Address split: offset=[3:0], index=[4+IDX-1:4], tag=[15:4+IDX]. Word select=[3:1].
- Arrays are flops with asynchronous read. Tag compare is combinational. hit = OR over ways of (valid and tag match).
- Reset (sync, rst=1 at posedge):
  - state=IDLE; all valid, dirty and PLRU bits=0; counters=0.
  - Outputs mem_resp, pmem_read and pmem_write are 0 the cycle after.
  - mem_rdata and pmem_wdata are don't-care but driven 0 in IDLE.
  - Reset mid-miss abandons the transaction; no line is written.
- States and transitions:
  - IDLE: if no request, stay. If request and hit, go to HIT. If miss and victim valid and dirty, go to WB. Otherwise go to FILL.
  - WB: pmem_write=1, pmem_address={victim tag, index, 4'h0}, pmem_wdata=victim line. Held stable until pmem_resp. On pmem_resp go to FILL.
  - FILL: pmem_read=1, pmem_address={mem_address[15:4], 4'h0}. On pmem_resp write pmem_rdata, tag, valid=1 and dirty=0 into the victim way, then go to HIT.
  - HIT: mem_resp=1 for exactly this cycle, then go to IDLE.
    - Read: mem_rdata = selected word of the hit way.
    - Write: merge mem_wdata bytes per mem_byte_enable into the hit word, set dirty=1.
    - Update PLRU in both cases.
- Latency:
  - Hit: mem_resp 1 cycle after the request is sampled. Back-to-back hits complete every 2 cycles.
  - Clean miss: 1 + fill latency + 1 cycles.
  - Dirty miss: adds the writeback latency.
- Victim selection:
  - Lowest-index invalid way first.
  - Otherwise walk the PLRU tree: WAYS-1 bits per set, node 0 = root, children of node n at 2n+1 and 2n+2. Bit 0 means go left (lower ways).
  - On any access to way w (hit or fill completion via HIT), each node on w's path is set to point away from w.
  - WAYS=2 reduces to a single LRU bit.
- Counters (16-bit, wrap 0xFFFF to 0):
  - hit_count increments on an IDLE-to-HIT transition.
  - miss_count increments on IDLE-to-WB or IDLE-to-FILL.
  - A missed access is counted only as a miss.
- CPU must hold address, data and request until mem_resp.
  - If the request drops during WB or FILL, the current pmem transaction completes and the line is installed, then go to IDLE with no mem_resp.
- mem_read and mem_write both high: treated as a write.
- pmem_resp outside WB/FILL is ignored.

Test Plan:
1. Cold read 0x1234, pmem_resp 3 cycles after pmem_read with the line's bytes 5:4 = 0x5566 -> pmem_address=0x1230, pmem_write never asserted, mem_resp with mem_rdata=0x5566, miss_count=1. Re-read 0x1234 -> mem_resp 1 cycle after request, no pmem_read, hit_count=1.
2. After scenario 1, write 0x1234, wdata=0xABCD, byte_enable=2'b01 -> hit; a following read returns 0x55CD; miss_count stays 1.
3. WAYS=4, SETS=8: write-miss 0x0030, read-miss 0x0130, 0x0230, 0x0330 (fill ways 0-3), then read 0x0030 (hit), then read 0x0430 -> victim is way 2 (0x0230, clean). Expect FILL only, pmem_address=0x0430.
4. Same as scenario 3 but with 0x0230 filled by a write-miss (dirty) -> WB with pmem_address=0x0230 and that line's data on pmem_wdata, then FILL of 0x0430, then mem_resp.
5. Assert rst for 1 cycle during FILL -> pmem_read=0 next cycle, counters=0. Re-reading a previously cached address misses.
6. mem_read=mem_write=1 on a hit to 0x1234 with wdata=0x0F0F, byte_enable=2'b11 -> treated as write; a later read returns 0x0F0F.
